// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Registers the winning request onto the ALU, waits SETTLE cycles, then returns the captured result.
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 2,
    parameter int FAIR   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [3:0]       r0_op,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [3:0]       r1_op,
    output logic             r0_rsp_valid,
    output logic             r1_rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state;
    logic       last_owner;
    logic       owner;
    logic [3:0] cnt;
    logic       grant;
    logic       accept;

    // When both request, FAIR alternates away from the last served owner; otherwise r0 wins.
    always_comb begin
        grant = 1'b0;
        if (r0_valid && r1_valid) begin
            grant = (FAIR != 0) ? ~last_owner : 1'b0;
        end else if (r1_valid) begin
            grant = 1'b1;
        end
    end

    assign r0_ready = reset_n && (state == IDLE) && r0_valid && !grant;
    assign r1_ready = reset_n && (state == IDLE) && r1_valid && grant;
    assign accept   = r0_ready || r1_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_owner   <= 1'b1;
            owner        <= 1'b0;
            cnt          <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            rsp_result   <= '0;
            rsp_cout     <= 1'b0;
            rsp_zero     <= 1'b0;
            r0_rsp_valid <= 1'b0;
            r1_rsp_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a  <= grant ? r1_a  : r0_a;
                        alu_b  <= grant ? r1_b  : r0_b;
                        alu_op <= grant ? r1_op : r0_op;
                        owner  <= grant;
                        cnt    <= CNT_INIT;
                        busy   <= 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_result   <= alu_result;
                        rsp_cout     <= alu_cout;
                        rsp_zero     <= alu_zero;
                        r0_rsp_valid <= !owner;
                        r1_rsp_valid <= owner;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    // Response data is left in place after the handshake; only the valids drop.
                    if (rsp_ready) begin
                        last_owner   <= owner;
                        r0_rsp_valid <= 1'b0;
                        r1_rsp_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
